// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues reads to a one-cycle synchronous ROM and
// buffers responses in a 2-entry FIFO. Branch redirect and HALT opcodes flush it.
module fetch_unit #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] pc_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_target,
  output logic          halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] infl_addr_q;
  logic [1:0]    count_q, count_d;
  logic [AW-1:0] addr_q  [2];
  logic [AW-1:0] addr_d  [2];
  logic [DW-1:0] instr_q [2];
  logic [DW-1:0] instr_d [2];

  logic       run;
  logic       xfer;
  logic       halt_xfer;
  logic       redirect;
  logic       flush;
  logic       push;
  logic       wr_idx;
  logic [1:0] occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && halt_xfer) state_d = HALTED;
  end

  always_comb begin
    run    = (state_q == RUN);
    halted = (state_q == HALTED);
  end

  // Occupancy counts the head leaving this edge so a full-rate stream
  // (one buffered, one in flight, one popped) keeps issuing every cycle.
  always_comb begin
    instr_valid = (count_q != 2'd0) && run;
    instr_out   = instr_q[0];
    pc_out      = addr_q[0];
    xfer        = instr_valid && instr_ready;
    halt_xfer   = xfer && (instr_q[0][DW-1 -: 4] == 4'hF);
    redirect    = branch_en && run && !halt_xfer;
    flush       = halt_xfer || redirect;
    occ         = count_q + 2'(inflight_q) - 2'(xfer);
    imem_en     = run && !branch_en && (occ < 2'd2);
    imem_addr   = pc_q;
    push        = inflight_q && !flush;
    wr_idx      = count_q[0] && !xfer;
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = imem_en && !halt_xfer;
    if (redirect)     pc_d = branch_target;
    else if (imem_en) pc_d = pc_q + AW'(1);
    count_d = flush ? 2'd0 : (count_q - 2'(xfer) + 2'(push));
  end

  always_comb begin
    addr_d  = addr_q;
    instr_d = instr_q;
    if (xfer) begin
      addr_d[0]  = addr_q[1];
      instr_d[0] = instr_q[1];
    end
    if (push) begin
      addr_d[wr_idx]  = infl_addr_q;
      instr_d[wr_idx] = imem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload needs no reset; count_q and inflight_q qualify it.
  always_ff @(posedge clk) begin
    addr_q[0]  <= addr_d[0];
    addr_q[1]  <= addr_d[1];
    instr_q[0] <= instr_d[0];
    instr_q[1] <= instr_d[1];
    if (imem_en) infl_addr_q <= pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for stream/stall/branch/wrap,
// plus hand sequences for asynchronous reset and HALT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        halted;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  fetch_unit #(.AW(8), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_en(branch_en),
    .branch_target(branch_target), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  typedef struct {
    logic       rdy;
    logic       br;
    logic [7:0] tgt;
    logic       v;
    logic [7:0] pc;
    logic       en;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int n = 0; n < 256; n++) rom[n] = 16'h1000 + 16'(n);

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h02};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h03};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h04};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h05};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h06};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h06};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h06};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h06};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h06};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h06};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h07};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h08};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h09};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 8'h0A};
    tbl[16] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h08, 1'b0, 8'h0A};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h40};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h42};
    tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h43};
    tbl[21] = '{1'b1, 1'b1, 8'hFE, 1'b1, 8'h42, 1'b0, 8'h44};
    tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFE};
    tbl[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF};
    tbl[24] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b1, 8'h00};
    tbl[25] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h01};
    tbl[26] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h02};
    tbl[27] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h03};

    rst = 1'b0;
    instr_ready = 1'b0;
    branch_en = 1'b0;
    branch_target = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      instr_ready   = tbl[i].rdy;
      branch_en     = tbl[i].br;
      branch_target = tbl[i].tgt;
      #1;
      chk($sformatf("c%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
      chk($sformatf("c%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
      chk($sformatf("c%0d_halted", i), 32'(halted), 32'd0);
      if (tbl[i].en) chk($sformatf("c%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      if (tbl[i].v) begin
        chk($sformatf("c%0d_pc", i), 32'(pc_out), 32'(tbl[i].pc));
        chk($sformatf("c%0d_instr", i), 32'(instr_out), 32'(16'h1000 + 16'(tbl[i].pc)));
      end
      @(negedge clk);
    end

    // Asynchronous reset between edges while the head sits at 8'h23
    instr_ready = 1'b1;
    branch_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      #1;
      if (instr_valid && pc_out == 8'h23) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_pc23", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_c0_valid", 32'(instr_valid), 32'd0);
    chk("rel_c0_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    #1;
    chk("rel_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_c2_valid", 32'(instr_valid), 32'd1);
    chk("rel_c2_pc", 32'(pc_out), 32'h00);
    @(negedge clk);
    #1;
    chk("rel_c3_pc", 32'(pc_out), 32'h01);
    @(negedge clk);

    // HALT at address 5, with a branch request in the halting cycle
    rst = 1'b1;
    rom[5] = 16'hF000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      branch_en = (i == 7);
      branch_target = 8'h30;
      #1;
      if (i >= 2) begin
        chk($sformatf("h%0d_valid", i), 32'(instr_valid), 32'd1);
        chk($sformatf("h%0d_pc", i), 32'(pc_out), 32'(i - 2));
      end
      if (i == 7) begin
        chk("h7_instr", 32'(instr_out), 32'hF000);
        chk("h7_halted", 32'(halted), 32'd0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      branch_en = k[0];
      branch_target = 8'h10;
      #1;
      chk($sformatf("halt%0d_halted", k), 32'(halted), 32'd1);
      chk($sformatf("halt%0d_valid", k), 32'(instr_valid), 32'd0);
      chk($sformatf("halt%0d_en", k), 32'(imem_en), 32'd0);
      @(negedge clk);
    end
    branch_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
